// File: rtl/hash160_pkg.sv
// Definitions shared by every Hash160 block: FSM states, message/digest geometry
// and the initial hash values of the SHA-256 and RIPEMD-160 stages.
package hash160_pkg;

    localparam int MSG_BYTES = 64;
    localparam int WORD_W    = 16;
    localparam int N_WORDS   = 10;
    localparam int DIGEST_W  = 160;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [159:0] RMD160_IV = {
        32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0
    };

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RECV
    } state_t;

endpackage

// File: rtl/hash160_word_collector.sv
// Assembles the core's response words into a digest and watches for a stalled core.
// full/timeout/value are combinational so the host can act on the edge that samples the word.
module hash160_word_collector
    import hash160_pkg::*;
#(
    parameter int WORD_W  = hash160_pkg::WORD_W,
    parameter int N_WORDS = hash160_pkg::N_WORDS,
    parameter int TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [WORD_W-1:0]           in_word,
    output logic                        full,
    output logic                        timeout,
    output logic [WORD_W*N_WORDS-1:0]   value
);

    localparam int VALUE_W = WORD_W * N_WORDS;
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    // Only the earlier words need storage; the newest one comes straight from in_word.
    logic [VALUE_W-WORD_W-1:0] shift;
    logic [3:0]                count;
    logic [IDLE_W-1:0]         idle;

    assign value   = {shift, in_word};
    assign full    = en && in_valid && (count == 4'(N_WORDS - 1));
    assign timeout = en && !in_valid && (idle >= IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift <= '0;
            count <= '0;
            idle  <= '0;
        end else if (en) begin
            if (in_valid) begin
                shift <= value[VALUE_W-WORD_W-1:0];
                count <= count + 4'd1;
                idle  <= '0;
            end else if (idle != IDLE_W'(TIMEOUT)) begin
                idle <= idle + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash160_host.sv
// Host-side initiator for the Hash160 core: serializes a 64-byte message into the core,
// then collects the 16-bit answer words into a 160-bit digest, flagging a stalled core.
module hash160_host
    import hash160_pkg::*;
#(
    parameter int MSG_BYTES = hash160_pkg::MSG_BYTES,
    parameter int WORD_W    = hash160_pkg::WORD_W,
    parameter int N_WORDS   = hash160_pkg::N_WORDS,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [8*MSG_BYTES-1:0]      msg,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [WORD_W*N_WORDS-1:0]   digest,
    output logic                        core_i_valid,
    output logic [7:0]                  core_i_text,
    input  logic                        core_o_valid,
    input  logic [WORD_W-1:0]           core_o_answer
);

    localparam int MSG_W      = 8 * MSG_BYTES;
    localparam int VALUE_W    = WORD_W * N_WORDS;
    localparam int BYTE_CNT_W = $clog2(MSG_BYTES);

    state_t                  state;
    logic [MSG_W-1:0]        shreg;
    logic [BYTE_CNT_W-1:0]   byte_cnt;

    logic                    col_en;
    logic                    col_clear;
    logic                    col_full;
    logic                    col_timeout;
    logic [VALUE_W-1:0]      col_value;

    // Outside WAIT/RECV the collector is held clear, so every wait starts from zero.
    assign col_en    = (state == WAIT) || (state == RECV);
    assign col_clear = !col_en;

    hash160_word_collector #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS),
        .TIMEOUT (TIMEOUT)
    ) u_collector (
        .clk      (clk),
        .rst      (rst),
        .clear    (col_clear),
        .en       (col_en),
        .in_valid (core_o_valid),
        .in_word  (core_o_answer),
        .full     (col_full),
        .timeout  (col_timeout),
        .value    (col_value)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch sees the values from before this edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            byte_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            digest       <= '0;
            core_i_valid <= 1'b0;
            core_i_text  <= 8'h00;
        end else begin
            done         <= 1'b0;
            err          <= 1'b0;
            core_i_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        core_i_text  <= msg[MSG_W-1 -: 8];
                        core_i_valid <= 1'b1;
                        shreg        <= msg << 8;
                        byte_cnt     <= '0;
                        busy         <= 1'b1;
                        state        <= SEND;
                    end
                end

                SEND: begin
                    if (byte_cnt == BYTE_CNT_W'(MSG_BYTES - 1)) begin
                        core_i_text <= 8'h00;
                        state       <= WAIT;
                    end else begin
                        core_i_text <= shreg[MSG_W-1 -: 8];
                        shreg       <= shreg << 8;
                        byte_cnt    <= byte_cnt + 1'b1;
                    end
                end

                WAIT, RECV: begin
                    if (col_full) begin
                        digest <= col_value;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (col_timeout) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (core_o_valid) begin
                        state <= RECV;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash160_host.sv
// Directed bench for hash160_host: one instance with the default timeout for the long-latency
// run, one with TIMEOUT = 16 for the gap and stall cases; both share one responder.
module tb_hash160_host;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [511:0] msg;
    logic         rsp_valid;
    logic [15:0]  rsp_word;

    logic         busy_a, done_a, err_a, civ_a;
    logic [7:0]   cit_a;
    logic [159:0] digest_a;
    logic         busy_b, done_b, err_b, civ_b;
    logic [7:0]   cit_b;
    logic [159:0] digest_b;

    int total = 0;
    int bad   = 0;

    localparam logic [159:0] EXP_DIGEST =
        160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A;

    hash160_host dut_a (
        .clk           (clk),
        .rst           (rst),
        .start         (start_a),
        .msg           (msg),
        .busy          (busy_a),
        .done          (done_a),
        .err           (err_a),
        .digest        (digest_a),
        .core_i_valid  (civ_a),
        .core_i_text   (cit_a),
        .core_o_valid  (rsp_valid),
        .core_o_answer (rsp_word)
    );

    hash160_host #(.TIMEOUT(16)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .start         (start_b),
        .msg           (msg),
        .busy          (busy_b),
        .done          (done_b),
        .err           (err_b),
        .digest        (digest_b),
        .core_i_valid  (civ_b),
        .core_i_text   (cit_b),
        .core_o_valid  (rsp_valid),
        .core_o_answer (rsp_word)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start instance A and check all 64 bytes; optionally pulse start (with a different msg)
    // at byte abuse_at. Returns in the first WAIT cycle.
    task automatic send_a(input logic [511:0] m, input int abuse_at);
        msg     = m;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_ivalid_first", civ_a, 1);
        check("a_byte0", cit_a, m[511 -: 8]);
        check("a_busy_send", busy_a, 1);
        for (int k = 1; k < 64; k++) begin
            if (k == abuse_at) begin
                start_a = 1'b1;
                msg     = ~m;
            end
            tick();
            start_a = 1'b0;
            msg     = m;
            check($sformatf("a_byte%0d", k), cit_a, m[511 - 8*k -: 8]);
            check("a_ivalid_low", civ_a, 0);
        end
        tick();
        check("a_busy_wait", busy_a, 1);
        check("a_ivalid_wait", civ_a, 0);
    endtask

    // Silent for delay cycles, then words 1..10 back-to-back; start pulsed with word pulse_at.
    task automatic respond_a(input int delay, input int pulse_at);
        rsp_valid = 1'b0;
        repeat (delay) begin
            tick();
            check("a_busy_idle_rsp", busy_a, 1);
        end
        for (int i = 1; i <= 10; i++) begin
            rsp_valid = 1'b1;
            rsp_word  = 16'(i);
            if (i == pulse_at) start_a = 1'b1;
            tick();
            start_a = 1'b0;
            if (i < 10) begin
                check("a_done_early", done_a, 0);
                check("a_busy_recv", busy_a, 1);
            end
        end
        // An extra word after the digest completes must be ignored.
        rsp_word = 16'hBEEF;
        check("a_done", done_a, 1);
        check("a_digest", digest_a, EXP_DIGEST);
        check("a_busy_after_done", busy_a, 0);
        tick();
        rsp_valid = 1'b0;
        check("a_done_one_cycle", done_a, 0);
        check("a_digest_held", digest_a, EXP_DIGEST);
        check("a_no_queued_start", busy_a, 0);
        tick();
        check("a_still_idle", busy_a, 0);
    endtask

    // Start instance B and skip over its byte stream; returns in the first WAIT cycle.
    task automatic send_b(input logic [511:0] m);
        msg     = m;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_ivalid_first", civ_b, 1);
        repeat (64) tick();
        check("b_busy_wait", busy_b, 1);
    endtask

    initial begin
        logic [511:0] ramp;
        logic [511:0] pat;
        int gap;

        for (int k = 0; k < 64; k++) begin
            ramp[511 - 8*k -: 8] = 8'(k);
            pat[511 - 8*k -: 8]  = 8'(k * 7 + 3);
        end

        // Reset held 3 cycles with start asserted: reset wins.
        rst       = 1'b1;
        start_a   = 1'b1;
        start_b   = 1'b1;
        msg       = ramp;
        rsp_valid = 1'b0;
        rsp_word  = 16'h0;
        repeat (3) tick();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_ivalid", civ_a, 0);
        check("rst_itext", cit_a, 0);
        check("rst_digest", digest_a, 0);
        check("rst_busy_b", busy_b, 0);
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tick();
        check("idle_busy", busy_a, 0);

        // Byte order plus digest assembly 40 cycles after SEND ends.
        send_a(ramp, -1);
        respond_a(40, 0);

        // Start pulsed during SEND and RECV is ignored.
        send_a(pat, 10);
        respond_a(3, 4);

        // Gaps of 0..5 cycles with TIMEOUT = 16.
        send_b(pat);
        for (int i = 1; i <= 10; i++) begin
            gap = $urandom_range(0, 5);
            rsp_valid = 1'b0;
            repeat (gap) begin
                tick();
                check("b_no_err_gap", err_b, 0);
            end
            rsp_valid = 1'b1;
            rsp_word  = 16'(i);
            tick();
            if (i < 10) check("b_done_early", done_b, 0);
        end
        rsp_valid = 1'b0;
        check("b_done", done_b, 1);
        check("b_digest", digest_b, EXP_DIGEST);
        check("b_err_gaps", err_b, 0);
        tick();
        check("b_done_pulse", done_b, 0);

        // Silent core: err in the 17th WAIT cycle, digest unchanged.
        send_b(ramp);
        for (int c = 1; c <= 15; c++) begin
            tick();
            check("b_err_early", err_b, 0);
            check("b_busy_stall", busy_b, 1);
        end
        tick();
        check("b_err", err_b, 1);
        check("b_busy_after_err", busy_b, 0);
        check("b_done_on_err", done_b, 0);
        check("b_digest_kept", digest_b, EXP_DIGEST);
        tick();
        check("b_err_pulse", err_b, 0);

        // Reset at byte 20, then a fresh start sends byte 0 again.
        msg     = pat;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (20) tick();
        check("a_byte20_pre_rst", cit_a, pat[511 - 160 -: 8]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ivalid", civ_a, 0);
        check("mid_rst_itext", cit_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_digest", digest_a, 0);
        tick();
        check("post_rst_itext", cit_a, 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart_ivalid", civ_a, 1);
        check("restart_byte0", cit_a, pat[511 -: 8]);
        tick();
        check("restart_byte1", cit_a, pat[503 -: 8]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hash160_host.md
# hash160_host

Host-side initiator for the Hash160 core (SHA-256 followed by RIPEMD-160). It takes a 64-byte message and streams it one byte per cycle into the core's `i_valid`/`i_text` port. It then collects the 16-bit words the core returns on `o_valid`/`o_answer` and assembles them into a 160-bit digest, raising an error if the core stalls. It sits between the system/testbench control logic and the Hash160 core.

## Interface
- `MSG_BYTES`, 64: bytes per message; the message bus width is 8·MSG_BYTES.
- `WORD_W`, 16: width of a response word.
- `N_WORDS`, 10: response words per digest (N_WORDS·WORD_W = 160).
- `TIMEOUT`, 1023: maximum consecutive idle cycles allowed in WAIT or RECV.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a run; honoured only in IDLE.
- `msg` in 512: message, captured on an accepted start; `msg[511:504]` is sent first.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the digest is valid.
- `err` out 1: one-cycle pulse on timeout.
- `digest` out 160: last good digest, MS word first; held until the next `done`.
- `core_i_valid` out 1: to core `i_valid`.
- `core_i_text` out 8: to core `i_text`.
- `core_o_valid` in 1: from core `o_valid`.
- `core_o_answer` in 16: from core `o_answer`.

## Operation
- **States:** IDLE, SEND, WAIT, RECV.
- **IDLE:**
  - On `start`: latch `msg` into the shift register, clear the byte counter, go to SEND.
  - `core_o_valid` is ignored in IDLE.
- **SEND:**
  - Runs exactly MSG_BYTES cycles. Each cycle drives `core_i_text` = top byte of the shift register, then shifts left by 8.
  - `core_i_valid` = 1 on the first SEND cycle only; 0 in all other cycles and states.
  - After the 64th byte, go to WAIT. `core_o_valid` is ignored during SEND.
- **WAIT:**
  - Clear the idle counter on entry.
  - First cycle with `core_o_valid` = 1: capture that word as word 0 and go to RECV.
- **RECV:**
  - Every cycle with `core_o_valid` = 1: `shift <= {shift[143:0], core_o_answer}`, word count +1, idle counter cleared.
  - Gaps (`core_o_valid` = 0) are legal.
  - When the N_WORDS-th word is captured, go to IDLE, load `digest` from the assembled shift value, and pulse `done`.
  - Words after the N_WORDS-th are ignored because the block is already in IDLE.
- **Timeout:**
  - In WAIT or RECV, the idle counter increments on every cycle without `core_o_valid`.
  - When it reaches TIMEOUT: pulse `err`, leave `digest` unchanged, discard the partial shift value, go to IDLE.
- **Start while busy:** ignored, no queueing.
- **`start` together with `rst`:** reset wins.
- **Reset (any state, including mid-SEND or mid-RECV), values on the following edge:**
  - state = IDLE; `busy`, `done`, `err`, `core_i_valid` = 0.
  - `core_i_text` = 8'h00; `digest` = 160'h0; all counters = 0.
  - Re-initialising the core between messages is the system's responsibility (the core does not return to its start state on its own).

## Timing
- All outputs are registered.
- `start` accepted at edge t:
  - `core_i_valid` = 1 in cycle t+1 only.
  - `core_i_text` = byte k in cycle t+1+k, for k = 0..63.
  - WAIT begins in cycle t+65.
- Final word sampled at edge u: `done` = 1 and the new `digest` are visible in cycle u+1; `busy` = 0 in cycle u+1; a new `start` can be accepted at edge u+1.
- Timeout: after TIMEOUT consecutive cycles without `core_o_valid`, `err` is high in the following cycle.
- Minimum latency from `start` to `done` is 65 cycles plus the core's compute time plus N_WORDS cycles.
- Idle counter width is clog2(TIMEOUT+1) and it saturates; the word counter is 4 bits.

## Structure
- **Package `hash160_pkg`:**
  - state enum (IDLE/SEND/WAIT/RECV);
  - constants MSG_BYTES, WORD_W, N_WORDS, DIGEST_W = 160;
  - the 256-bit SHA-256 IV and the 160-bit RIPEMD-160 IV, so all Hash160 blocks share one definition.
- **Sub-module `hash160_word_collector`:**
  - word shift register, word counter and idle/timeout counter;
  - interface: `clk`, `rst`, `clear`, `en`, `in_valid`, `in_word` → `full`, `timeout`, `value`.
- **Top level:** holds the FSM and the byte serializer.

## Test plan
1. **Reset values:** hold `rst` 3 cycles, including while `start` = 1 → all outputs 0, `digest` = 0, `busy` = 0.
2. **Byte order:** `msg` = bytes 8'h00..8'h3F (MS first) → `core_i_valid` high only at t+1; `core_i_text` = 8'h00 at t+1 and 8'h3F at t+64; `busy` falls never before `done`.
3. **Digest assembly:** responder model returns 16'h0001..16'h000A back-to-back starting 40 cycles after SEND ends → `digest` = 160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A; one-cycle `done`.
4. **Gaps:** same words with random 0–5 cycle gaps, TIMEOUT = 16 → same digest; no `err`.
5. **Timeout:** TIMEOUT = 16, responder silent → `err` pulse 17 cycles into WAIT; `digest` keeps its previous value; `busy` = 0.
6. **Protocol abuse:**
   - `start` pulsed during SEND and RECV → ignored, byte stream unchanged.
   - `rst` at byte 20 → `core_i_valid` = 0 and `core_i_text` = 0 from the next cycle; a fresh start sends byte 0 again.
